// File: rtl/nvdla_csb2reg_target_pkg.sv
// Shared definitions for the CSB register target: FSM encoding, CSB field
// widths and the legal register-file read latency range.
package nvdla_csb2reg_target_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // Wide enough to hold RD_LAT_MAX
   localparam int CNT_W      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_WAIT = 2'd2,
      RSP     = 2'd3
   } csb_state_e;

   // True when a read latency can be supported by the wait counter
   function automatic logic rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/nvdla_csb_addr_dec.sv
// Word-address window decoder: flags a hit when the address lies inside
// [BASE_ADDR, BASE_ADDR+ADDR_SPAN) and produces the window-relative offset.
// The upper bound is formed one bit wider so a window ending at the top of
// the address space never wraps around to zero.
module nvdla_csb_addr_dec
   import nvdla_csb2reg_target_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
   parameter logic [ADDR_W-1:0] ADDR_SPAN = 16'h1000
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_hit,
   output logic [ADDR_W-1:0] o_offset
);

   localparam logic [ADDR_W:0] LP_LO = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] LP_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

   logic [ADDR_W:0] w_addr;

   assign w_addr   = {1'b0, i_addr};
   assign o_hit    = (w_addr >= LP_LO) && (w_addr < LP_HI);
   assign o_offset = i_addr - BASE_ADDR;

endmodule

// File: rtl/nvdla_csb2reg_target.sv
// CSB target stage: accepts one CSB request at a time, decodes it against a
// word-address window, strobes a unit register file for one cycle and
// returns read data or non-posted write completions to the bridge.
// Accesses outside the window still complete with normal timing (reads
// return zero) and raise a one-cycle decode-error pulse.
module nvdla_csb2reg_target
   import nvdla_csb2reg_target_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
   parameter logic [ADDR_W-1:0] ADDR_SPAN = 16'h1000,
   parameter int                RD_LAT    = 1
) (
   input  logic              pclk,
   input  logic              prstn,

   input  logic              csb2nvdla_valid,
   output logic              csb2nvdla_ready,
   input  logic [ADDR_W-1:0] csb2nvdla_addr,
   input  logic [DATA_W-1:0] csb2nvdla_wdat,
   input  logic              csb2nvdla_write,
   input  logic              csb2nvdla_nposted,

   output logic              nvdla2csb_valid,
   output logic [DATA_W-1:0] nvdla2csb_data,
   output logic              nvdla2csb_wr_complete,

   output logic              reg_rd_en,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_offset,
   output logic [DATA_W-1:0] reg_wr_data,
   input  logic [DATA_W-1:0] reg_rd_data,

   output logic              dec_err
);

   if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
      $error("nvdla_csb2reg_target: RD_LAT=%0d outside legal range %0d..%0d",
             RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
   end

   localparam logic [CNT_W-1:0] LP_RD_LAT = CNT_W'(RD_LAT);

   csb_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_hit;
   logic              r_rdEn;
   logic              r_wrEn;
   logic              r_decErr;
   logic              r_wrCmp;
   logic              r_rspVld;
   logic [DATA_W-1:0] r_rspData;
   logic [ADDR_W-1:0] r_offset;
   logic [DATA_W-1:0] r_wrData;

   logic              w_hit;
   logic [ADDR_W-1:0] w_offset;
   logic              w_accept;

   nvdla_csb_addr_dec #(
      .BASE_ADDR (BASE_ADDR),
      .ADDR_SPAN (ADDR_SPAN)
   ) u_addr_dec (
      .i_addr   (csb2nvdla_addr),
      .o_hit    (w_hit),
      .o_offset (w_offset)
   );

   assign csb2nvdla_ready = (r_state == IDLE);
   assign w_accept        = csb2nvdla_valid && csb2nvdla_ready;

   // Request FSM with registered strobes: every strobe defaults low each
   // cycle so it can only ever be a single-cycle pulse, and the response
   // data is forced back to zero outside the response cycle.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_hit     <= 1'b0;
         r_rdEn    <= 1'b0;
         r_wrEn    <= 1'b0;
         r_decErr  <= 1'b0;
         r_wrCmp   <= 1'b0;
         r_rspVld  <= 1'b0;
         r_rspData <= '0;
         r_offset  <= '0;
         r_wrData  <= '0;
      end else begin
         r_rdEn    <= 1'b0;
         r_wrEn    <= 1'b0;
         r_decErr  <= 1'b0;
         r_wrCmp   <= 1'b0;
         r_rspVld  <= 1'b0;
         r_rspData <= '0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_hit    <= w_hit;
                  r_offset <= w_offset;
                  r_decErr <= ~w_hit;
                  if (csb2nvdla_write) begin
                     r_wrData <= csb2nvdla_wdat;
                     r_wrEn   <= w_hit;
                     r_wrCmp  <= csb2nvdla_nposted;
                     r_state  <= WR;
                  end else begin
                     r_rdEn   <= w_hit;
                     r_cnt    <= LP_RD_LAT;
                     r_state  <= RD_WAIT;
                  end
               end
            end
            WR: begin
               r_state <= IDLE;
            end
            RD_WAIT: begin
               if (r_cnt == '0) begin
                  r_rspData <= r_hit ? reg_rd_data : '0;
                  r_rspVld  <= 1'b1;
                  r_state   <= RSP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RSP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign nvdla2csb_valid       = r_rspVld;
   assign nvdla2csb_data        = r_rspData;
   assign nvdla2csb_wr_complete = r_wrCmp;
   assign reg_rd_en             = r_rdEn;
   assign reg_wr_en             = r_wrEn;
   assign reg_offset            = r_offset;
   assign reg_wr_data           = r_wrData;
   assign dec_err               = r_decErr;

endmodule

// File: tb/tb_nvdla_csb2reg_target.sv
// Self-checking bench for nvdla_csb2reg_target. Two targets with RD_LAT=1
// and RD_LAT=4 share the request inputs; each has its own register-file
// model that only presents valid data in the exact expected cycle.
module tb_nvdla_csb2reg_target;

   logic        pclk;
   logic        prstn;
   logic        valid;
   logic [15:0] addr;
   logic [31:0] wdat;
   logic        write;
   logic        nposted;
   logic [31:0] rdValue;

   logic        ready1, rspVld1, wrCmp1, rdEn1, wrEn1, decErr1;
   logic [31:0] rspData1, wrData1, rdData1;
   logic [15:0] offset1;
   logic        ready4, rspVld4, wrCmp4, rdEn4, wrEn4, decErr4;
   logic [31:0] rspData4, wrData4, rdData4;
   logic [15:0] offset4;

   logic [3:0]  pipe1, pipe4;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        write;
      logic        nposted;
      logic [15:0] addr;
      logic [31:0] wdat;
      logic [31:0] rdVal;
      logic        expHit;
      logic [15:0] expOffset;
      logic [31:0] expData;
   } vec_t;

   typedef struct {
      int          readyAt;
      int          wrEnCnt;
      int          wrEnAt;
      int          rdEnCnt;
      int          rdEnAt;
      int          errCnt;
      int          errAt;
      int          cmpCnt;
      int          cmpAt;
      int          vldCnt;
      int          vldAt;
      int          leak;
      logic [31:0] rspData;
      logic [15:0] offsetT1;
      logic [31:0] wrDataT1;
   } obs_t;

   vec_t vecs [10];
   obs_t obs  [2];

   nvdla_csb2reg_target #(.BASE_ADDR(16'h0000), .ADDR_SPAN(16'h1000), .RD_LAT(1)) dut1 (
      .pclk                  (pclk),
      .prstn                 (prstn),
      .csb2nvdla_valid       (valid),
      .csb2nvdla_ready       (ready1),
      .csb2nvdla_addr        (addr),
      .csb2nvdla_wdat        (wdat),
      .csb2nvdla_write       (write),
      .csb2nvdla_nposted     (nposted),
      .nvdla2csb_valid       (rspVld1),
      .nvdla2csb_data        (rspData1),
      .nvdla2csb_wr_complete (wrCmp1),
      .reg_rd_en             (rdEn1),
      .reg_wr_en             (wrEn1),
      .reg_offset            (offset1),
      .reg_wr_data           (wrData1),
      .reg_rd_data           (rdData1),
      .dec_err               (decErr1)
   );

   nvdla_csb2reg_target #(.BASE_ADDR(16'h0000), .ADDR_SPAN(16'h1000), .RD_LAT(4)) dut4 (
      .pclk                  (pclk),
      .prstn                 (prstn),
      .csb2nvdla_valid       (valid),
      .csb2nvdla_ready       (ready4),
      .csb2nvdla_addr        (addr),
      .csb2nvdla_wdat        (wdat),
      .csb2nvdla_write       (write),
      .csb2nvdla_nposted     (nposted),
      .nvdla2csb_valid       (rspVld4),
      .nvdla2csb_data        (rspData4),
      .nvdla2csb_wr_complete (wrCmp4),
      .reg_rd_en             (rdEn4),
      .reg_wr_en             (wrEn4),
      .reg_offset            (offset4),
      .reg_wr_data           (wrData4),
      .reg_rd_data           (rdData4),
      .dec_err               (decErr4)
   );

   // Free-running clock
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Register-file models: data is valid only RD_LAT cycles after the strobe
   always @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         pipe1 <= 4'b0;
         pipe4 <= 4'b0;
      end else begin
         pipe1 <= {pipe1[2:0], rdEn1};
         pipe4 <= {pipe4[2:0], rdEn4};
      end
   end

   assign rdData1 = pipe1[0] ? rdValue : 32'hBAD0BAD0;
   assign rdData4 = pipe4[3] ? rdValue : 32'hBAD0BAD0;

   // Watchdog so the run always terminates
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic obs_t emptyObs();
      obs_t o;
      o.readyAt  = -1;
      o.wrEnCnt  = 0;
      o.wrEnAt   = -1;
      o.rdEnCnt  = 0;
      o.rdEnAt   = -1;
      o.errCnt   = 0;
      o.errAt    = -1;
      o.cmpCnt   = 0;
      o.cmpAt    = -1;
      o.vldCnt   = 0;
      o.vldAt    = -1;
      o.leak     = 0;
      o.rspData  = 32'hFFFF_FFFF;
      o.offsetT1 = 16'hFFFF;
      o.wrDataT1 = 32'hFFFF_FFFF;
      return o;
   endfunction

   task automatic noteCycle(input int d, input int i, input logic rdy, input logic vld,
                            input logic [31:0] dat, input logic cmp, input logic rdEn,
                            input logic wrEn, input logic [15:0] off, input logic [31:0] wd,
                            input logic err);
      if (rdy && obs[d].readyAt < 0) obs[d].readyAt = i;
      if (wrEn) begin
         obs[d].wrEnCnt++;
         if (obs[d].wrEnAt < 0) obs[d].wrEnAt = i;
      end
      if (rdEn) begin
         obs[d].rdEnCnt++;
         if (obs[d].rdEnAt < 0) obs[d].rdEnAt = i;
      end
      if (err) begin
         obs[d].errCnt++;
         if (obs[d].errAt < 0) obs[d].errAt = i;
      end
      if (cmp) begin
         obs[d].cmpCnt++;
         if (obs[d].cmpAt < 0) obs[d].cmpAt = i;
      end
      if (vld) begin
         obs[d].vldCnt++;
         if (obs[d].vldAt < 0) begin
            obs[d].vldAt   = i;
            obs[d].rspData = dat;
         end
      end else if (dat != 32'h0) begin
         obs[d].leak++;
      end
      if (i == 1) begin
         obs[d].offsetT1 = off;
         obs[d].wrDataT1 = wd;
      end
   endtask

   task automatic observe(input int hold, input int window);
      obs[0] = emptyObs();
      obs[1] = emptyObs();
      for (int i = 1; i <= window; i++) begin
         @(negedge pclk);
         noteCycle(0, i, ready1, rspVld1, rspData1, wrCmp1, rdEn1, wrEn1, offset1, wrData1, decErr1);
         noteCycle(1, i, ready4, rspVld4, rspData4, wrCmp4, rdEn4, wrEn4, offset4, wrData4, decErr4);
         if (i == hold) valid = 1'b0;
      end
   endtask

   // Drives one request in cycle T (valid held for 'hold' cycles) and observes
   task automatic applyStimulus(input vec_t v, input int hold, input string tag);
      @(negedge pclk);
      checkOutput({tag, " ready1 before"}, 32'(ready1), 32'd1);
      checkOutput({tag, " ready4 before"}, 32'(ready4), 32'd1);
      rdValue = v.rdVal;
      addr    = v.addr;
      wdat    = v.wdat;
      write   = v.write;
      nposted = v.nposted;
      valid   = 1'b1;
      observe(hold, 10);
   endtask

   // Compares the recorded observations against the timing the target must meet
   task automatic checkTxn(input vec_t v, input string tag);
      for (int d = 0; d < 2; d++) begin
         int    lat;
         string n;
         lat = (d == 0) ? 1 : 4;
         n   = $sformatf("%s lat%0d", tag, lat);
         checkOutput({n, " offset"},  32'(obs[d].offsetT1), 32'(v.expOffset));
         checkOutput({n, " errCnt"},  32'(obs[d].errCnt),   v.expHit ? 32'd0 : 32'd1);
         checkOutput({n, " errAt"},   32'(obs[d].errAt),    v.expHit ? 32'hFFFF_FFFF : 32'd1);
         checkOutput({n, " leak"},    32'(obs[d].leak),     32'd0);
         if (v.write) begin
            checkOutput({n, " wrEnCnt"}, 32'(obs[d].wrEnCnt),  v.expHit ? 32'd1 : 32'd0);
            checkOutput({n, " wrEnAt"},  32'(obs[d].wrEnAt),   v.expHit ? 32'd1 : 32'hFFFF_FFFF);
            checkOutput({n, " wrData"},  obs[d].wrDataT1,      v.wdat);
            checkOutput({n, " cmpCnt"},  32'(obs[d].cmpCnt),   v.nposted ? 32'd1 : 32'd0);
            checkOutput({n, " cmpAt"},   32'(obs[d].cmpAt),    v.nposted ? 32'd1 : 32'hFFFF_FFFF);
            checkOutput({n, " rdEnCnt"}, 32'(obs[d].rdEnCnt),  32'd0);
            checkOutput({n, " vldCnt"},  32'(obs[d].vldCnt),   32'd0);
            checkOutput({n, " readyAt"}, 32'(obs[d].readyAt),  32'd2);
         end else begin
            checkOutput({n, " rdEnCnt"}, 32'(obs[d].rdEnCnt),  v.expHit ? 32'd1 : 32'd0);
            checkOutput({n, " rdEnAt"},  32'(obs[d].rdEnAt),   v.expHit ? 32'd1 : 32'hFFFF_FFFF);
            checkOutput({n, " wrEnCnt"}, 32'(obs[d].wrEnCnt),  32'd0);
            checkOutput({n, " cmpCnt"},  32'(obs[d].cmpCnt),   32'd0);
            checkOutput({n, " vldCnt"},  32'(obs[d].vldCnt),   32'd1);
            checkOutput({n, " vldAt"},   32'(obs[d].vldAt),    32'(2 + lat));
            checkOutput({n, " rspData"}, obs[d].rspData,       v.expData);
            checkOutput({n, " readyAt"}, 32'(obs[d].readyAt),  32'(3 + lat));
         end
      end
   endtask

   initial begin
      vec_t vHold;

      //          write nposted addr      wdat          rdVal         hit   offset    data
      vecs[0] = '{1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0000_0000, 1'b1, 16'h0010, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 16'h0FFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 16'h0FFF, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 16'h1000, 32'hA5A5A5A5, 32'h0000_0000, 1'b0, 16'h1000, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 16'h0020, 32'h0000_0000, 32'h12345678, 1'b1, 16'h0020, 32'h12345678};
      vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 32'h0000_0000, 32'h0BADF00D, 1'b0, 16'hFFFF, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'hCAFEF00D, 1'b1, 16'h0000, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b0, 16'h0000, 32'h13579BDF, 32'h0000_0000, 1'b1, 16'h0000, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 16'h8000, 32'h2468ACE0, 32'h0000_0000, 1'b0, 16'h8000, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 16'h0FFF, 32'h0000_0000, 32'hFFFFFFFF, 1'b1, 16'h0FFF, 32'hFFFFFFFF};
      vecs[9] = '{1'b0, 1'b0, 16'h1000, 32'h0000_0000, 32'h77777777, 1'b0, 16'h1000, 32'h0};

      // Reset held with a write request pending: nothing may be accepted
      prstn   = 1'b0;
      valid   = 1'b1;
      addr    = 16'h0010;
      wdat    = 32'h0F0F0F0F;
      write   = 1'b1;
      nposted = 1'b1;
      rdValue = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge pclk);
         checkOutput($sformatf("rst c%0d ready1", c),  32'(ready1),  32'd1);
         checkOutput($sformatf("rst c%0d ready4", c),  32'(ready4),  32'd1);
         checkOutput($sformatf("rst c%0d wrEn1", c),   32'(wrEn1),   32'd0);
         checkOutput($sformatf("rst c%0d cmp1", c),    32'(wrCmp1),  32'd0);
         checkOutput($sformatf("rst c%0d err1", c),    32'(decErr1), 32'd0);
         checkOutput($sformatf("rst c%0d rdEn1", c),   32'(rdEn1),   32'd0);
         checkOutput($sformatf("rst c%0d vld4", c),    32'(rspVld4), 32'd0);
         checkOutput($sformatf("rst c%0d data4", c),   rspData4,     32'd0);
         checkOutput($sformatf("rst c%0d offset1", c), 32'(offset1), 32'd0);
         checkOutput($sformatf("rst c%0d wrData1", c), wrData1,      32'd0);
      end
      prstn = 1'b1;
      @(negedge pclk);
      checkOutput("post-rst accept wrEn1",   32'(wrEn1),   32'd1);
      checkOutput("post-rst accept wrEn4",   32'(wrEn4),   32'd1);
      checkOutput("post-rst accept cmp1",    32'(wrCmp1),  32'd1);
      checkOutput("post-rst accept offset1", 32'(offset1), 32'h0010);
      checkOutput("post-rst accept wrData1", wrData1,      32'h0F0F0F0F);
      valid = 1'b0;
      repeat (2) @(negedge pclk);

      // Table of single transactions
      for (int k = 0; k < 10; k++) begin
         applyStimulus(vecs[k], 1, $sformatf("v%0d", k));
         checkTxn(vecs[k], $sformatf("v%0d", k));
      end

      // Read with valid held while the target is busy: only one acceptance
      vHold = '{1'b0, 1'b0, 16'h0040, 32'h0, 32'h5555AAAA, 1'b1, 16'h0040, 32'h5555AAAA};
      applyStimulus(vHold, 3, "hold");
      checkTxn(vHold, "hold");

      // Reset asserted in T+1 of a read: no response, ready restored at once
      @(negedge pclk);
      rdValue = 32'h99887766;
      addr    = 16'h0020;
      write   = 1'b0;
      nposted = 1'b0;
      valid   = 1'b1;
      @(negedge pclk);
      valid = 1'b0;
      checkOutput("midrst rdEn1 before", 32'(rdEn1),  32'd1);
      checkOutput("midrst ready1 busy",  32'(ready1), 32'd0);
      prstn = 1'b0;
      #1;
      checkOutput("midrst ready1", 32'(ready1), 32'd1);
      checkOutput("midrst ready4", 32'(ready4), 32'd1);
      checkOutput("midrst rdEn1",  32'(rdEn1),  32'd0);
      repeat (2) @(negedge pclk);
      prstn = 1'b1;
      observe(0, 8);
      checkOutput("midrst vldCnt1", 32'(obs[0].vldCnt), 32'd0);
      checkOutput("midrst vldCnt4", 32'(obs[1].vldCnt), 32'd0);
      checkOutput("midrst rdEnCnt1", 32'(obs[0].rdEnCnt), 32'd0);

      // A fresh read after the aborted one completes normally
      applyStimulus(vecs[3], 1, "after-rst");
      checkTxn(vecs[3], "after-rst");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/nvdla_csb2reg_target.md
Name: nvdla_csb2reg_target

Overview:
- CSB target stage directly downstream of the APB-to-CSB bridge. It accepts one CSB request at a time and decodes it against a word-address window.
- It drives a simple single-cycle-strobe register port toward a unit register file.
- It returns read data and non-posted write completions on the CSB response side, where the bridge consumes them to complete APB reads.

Parameters:
- BASE_ADDR, 16'h0000, first CSB word address owned by this target.
- ADDR_SPAN, 16'h1000, number of word addresses owned. Hit when BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN, compared at 17 bits so the window never wraps.
- RD_LAT, 1, register-file read latency in cycles; legal range 1..4.

Ports:
- pclk  in  1  clock; single clock domain.
- prstn  in  1  asynchronous active-low reset.
- csb2nvdla_valid  in  1  request valid.
- csb2nvdla_ready  out  1  target can accept a request.
- csb2nvdla_addr  in  16  word address.
- csb2nvdla_wdat  in  32  write data.
- csb2nvdla_write  in  1  1=write, 0=read.
- csb2nvdla_nposted  in  1  write requires completion.
- nvdla2csb_valid  out  1  read response pulse.
- nvdla2csb_data  out  32  read data; 0 when nvdla2csb_valid=0.
- nvdla2csb_wr_complete  out  1  non-posted write completion pulse.
- reg_rd_en  out  1  register read strobe.
- reg_wr_en  out  1  register write strobe.
- reg_offset  out  16  addr - BASE_ADDR.
- reg_wr_data  out  32  write data to registers.
- reg_rd_data  in  32  register read data, valid RD_LAT cycles after reg_rd_en.
- dec_err  out  1  one-cycle pulse on an out-of-window access.

Behaviour:
- Reset: the async assert of prstn forces state IDLE. nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete, reg_rd_en, reg_wr_en and dec_err all go to 0. reg_offset, reg_wr_data and the latched request go to 0. csb2nvdla_ready=1.
- Reset mid-transaction drops the outstanding request; no response is issued.
- csb2nvdla_ready = (state==IDLE), decoded from the state register.
- Acceptance is valid&ready in cycle T. Addr, wdat, write, nposted and hit are latched in cycle T. Inputs are ignored whenever ready=0.
- States: IDLE, WR, RD_WAIT, RSP. All outputs except ready are registered.
- Write, accepted at T:
  - IDLE->WR. At T+1: reg_wr_en=hit, reg_offset and reg_wr_data valid, dec_err=~hit.
  - nvdla2csb_wr_complete=nposted at T+1, issued for misses too.
  - WR->IDLE, so ready=1 at T+2.
- Read, accepted at T:
  - IDLE->RD_WAIT. At T+1: reg_rd_en=hit, reg_offset valid, dec_err=~hit.
  - A counter loads RD_LAT and decrements each RD_WAIT cycle.
  - At T+1+RD_LAT, sample reg_rd_data if hit, else 32'h0. Go to RSP.
  - At T+2+RD_LAT: nvdla2csb_valid=1 with the data for exactly one cycle.
  - RSP->IDLE, so ready=1 at T+3+RD_LAT.
  - Hit and miss timing are identical.
- Strobes reg_rd_en, reg_wr_en, dec_err, nvdla2csb_wr_complete and nvdla2csb_valid are single-cycle pulses, never back-to-back within one transaction.
- No request overlap: at most one outstanding transaction.
- nvdla2csb_data returns to 0 the cycle after the response pulse.
- RD_LAT outside 1..4 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, WR=2'd1, RD_WAIT=2'd2, RSP=2'd3);
  - CSB field widths (ADDR_W=16, DATA_W=32);
  - the RD_LAT legal-range constants.
- One natural sub-module is nvdla_csb_addr_dec: a combinational window hit and offset subtract, reused by other targets.
- FSM and datapath stay in the top.

Test Plan:
- Reset with csb2nvdla_valid=1 held -> all outputs 0, ready=1, and nothing accepted before prstn deasserts; first accept on the first clock after release.
- Posted write, addr=16'h0010, wdat=32'hDEADBEEF, BASE=0 -> reg_wr_en at T+1 with reg_offset=16'h0010, reg_wr_data=32'hDEADBEEF; wr_complete=0; ready=1 at T+2.
- Non-posted write, addr=16'h0FFF -> reg_wr_en and wr_complete both at T+1; addr=16'h1000 instead -> no reg_wr_en, dec_err=1, wr_complete=1 at T+1.
- Read, addr=16'h0020, RD_LAT=1, regfile returns 32'h12345678 -> reg_rd_en at T+1, nvdla2csb_valid at T+3 with data 32'h12345678, ready at T+4. Repeat with RD_LAT=4 -> valid at T+6.
- Read miss, addr=16'hFFFF -> dec_err at T+1, no reg_rd_en, valid at T+2+RD_LAT with data 32'h0.
- prstn asserted at T+1 of a read -> no nvdla2csb_valid ever issued, ready=1 immediately; a new read after release completes normally.
